// File: rtl/wb_pkg.sv
// Shared Wishbone slave definitions: ack-timer FSM states, default bus widths
// and the register-index width helper.
package wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } wb_state_e;

  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 32;

  // A single register still needs a 1-bit index so the select slice stays legal.
  function automatic int idx_w(input int num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

endpackage

// File: rtl/wb_ack_timer.sv
// Wishbone classic ack timer: counts request cycles up to ACK_LATENCY, then
// holds a one-cycle response phase. load_o marks the edge that enters it.
module wb_ack_timer
  import wb_pkg::*;
#(
  parameter int ACK_LATENCY = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_i,
  output logic resp_o,
  output logic load_o
);

  localparam int CNT_W = $clog2(ACK_LATENCY + 1);
  localparam logic [CNT_W-1:0] LAT = CNT_W'(ACK_LATENCY);

  wb_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             resp_q;

  assign load_o = req_i && (((state_q == ST_IDLE) && (ACK_LATENCY == 1)) ||
                            ((state_q == ST_WAIT) && ((cnt_q + CNT_W'(1)) == LAT)));
  assign resp_o = resp_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      resp_q  <= 1'b0;
    end else begin
      resp_q <= load_o;
      case (state_q)
        ST_IDLE: begin
          if (load_o) begin
            state_q <= ST_RESP;
            cnt_q   <= '0;
          end else if (req_i) begin
            state_q <= ST_WAIT;
            cnt_q   <= CNT_W'(1);
          end else begin
            cnt_q   <= '0;
          end
        end
        ST_WAIT: begin
          if (load_o) begin
            state_q <= ST_RESP;
            cnt_q   <= '0;
          end else if (req_i) begin
            cnt_q   <= cnt_q + CNT_W'(1);
          end else begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/wb_regfile_slave.sv
// Wishbone classic register-file slave with byte-lane writes and a fixed ack
// latency. Define WB_REGFILE_ERR_EN to answer out-of-range accesses with err.
module wb_regfile_slave
  import wb_pkg::*;
#(
  parameter int DATA_W      = WB_DATA_W,
  parameter int ADDR_W      = WB_ADDR_W,
  parameter int NUM_REGS    = 8,
  parameter int ACK_LATENCY = 8
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [DATA_W-1:0]   data_in,
  input  logic [DATA_W/8-1:0] sel_in,
  input  logic [ADDR_W-1:0]   addr_in,
  input  logic                cyc_in,
  input  logic                strobe_in,
  input  logic                we_in,
  output logic [DATA_W-1:0]   data_out,
  output logic                ack_out,
  output logic                err_out
);

  localparam int IDX_W = idx_w(NUM_REGS);
  localparam int NB    = DATA_W / 8;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;
  logic [IDX_W-1:0]  idx_s;
  logic              req_s;
  logic              in_range_s;
  logic              resp_s;
  logic              load_s;
  logic              done_s;
  logic              commit_s;

  assign req_s      = cyc_in && strobe_in;
  assign in_range_s = addr_in < ADDR_W'(NUM_REGS);
  assign idx_s      = addr_in[IDX_W-1:0];
  assign done_s     = resp_s && req_s;
  assign commit_s   = done_s && in_range_s && we_in;
  assign data_out   = data_q;

`ifdef WB_REGFILE_ERR_EN
  assign ack_out = done_s && in_range_s;
  assign err_out = done_s && !in_range_s;
`else
  assign ack_out = done_s;
  assign err_out = 1'b0;
`endif

  wb_ack_timer #(
    .ACK_LATENCY(ACK_LATENCY)
  ) u_timer (
    .clk_i (clock),
    .rst_ni(reset_n),
    .req_i (req_s),
    .resp_o(resp_s),
    .load_o(load_s)
  );

  // Out-of-range reads return zero rather than an aliased register.
  always_comb begin
    data_d = '0;
    if (in_range_s) begin
      data_d = regs_q[idx_s];
    end else begin
      data_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
    end else if (load_s) begin
      data_q <= data_d;
    end else begin
      data_q <= data_q;
    end
  end

  // Commit happens on the edge leaving the response cycle, so the read data
  // captured on entry still shows the pre-write value.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (commit_s) begin
      for (int b = 0; b < NB; b++) begin
        if (sel_in[b]) begin
          regs_q[idx_s][8*b +: 8] <= data_in[8*b +: 8];
        end
      end
    end
  end

endmodule
